wb_trace_fifo: RTL and testbench

//  Read-side capture of the CPU's architectural write events (GRF writeback, DM store).

---
 rtl/wb_trace_fifo.sv | 137 +++++++++++++
 tb/tb_wb_trace_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
//   Captures the CPU's architectural write events and queues them for a trace
//   consumer. There are two kinds of event: GRF writebacks to a nonzero
//   register, and DM stores. The CPU is never stalled. When the buffer has no
//   room, the event is dropped and counted instead.
//
//   Ports
//     clk, reset               rising-edge clock, synchronous active-high reset
//     grf_we/addr/wdata        register-file write strobe and payload
//     dm_we/addr/wdata         data-memory store strobe and payload
//     pc                       PC of the instruction producing the write(s)
//     trace_valid/ready        show-ahead head entry handshake
//     trace_kind/pc/addr/data  head entry fields; kind 0 = GRF, 1 = DM
//     count                    occupied entries, 0..DEPTH
//     overflow, dropped_cnt    sticky drop flag, saturating drop counter
//
//   Occupancy (derived from count_q, no separate state register)
//     state | meaning
//     EMPTY | count == 0, trace_valid low, head fields forced to 0
//     PART  | 1..DEPTH-1 entries
//     FULL  | count == DEPTH, every new event is dropped
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grf_we,
  input  logic [4:0]        grf_addr,
  input  logic [31:0]       grf_wdata,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [31:0]       pc,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic              trace_kind,
  output logic [31:0]       trace_pc,
  output logic [31:0]       trace_addr,
  output logic [31:0]       trace_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [15:0]       dropped_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO_C   = (ADDR_W+1)'(2);

  logic              mem_kind [DEPTH];
  logic [31:0]       mem_pc   [DEPTH];
  logic [31:0]       mem_addr [DEPTH];
  logic [31:0]       mem_data [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       dropped_q, dropped_d;

  logic              grf_ev, dm_ev, push_grf, push_dm, pop;
  logic [1:0]        n_push, n_drop;
  logic [ADDR_W:0]   free;
  logic [ADDR_W-1:0] dm_slot;
  logic [16:0]       drop_sum;

  always_comb begin
    // Writes to $zero are architecturally invisible and are not events.
    grf_ev   = grf_we && (grf_addr != 5'd0);
    dm_ev    = dm_we;
    // Free space is taken from the count at the start of the cycle. A pop in
    // the same cycle does not free a slot for this cycle's pushes.
    free     = DEPTH_C - count_q;
    push_grf = grf_ev && (free >= ONE_C);
    push_dm  = dm_ev && (free >= (grf_ev ? TWO_C : ONE_C));
    n_push   = {1'b0, push_grf} + {1'b0, push_dm};
    n_drop   = {1'b0, grf_ev && !push_grf} + {1'b0, dm_ev && !push_dm};
    pop      = (count_q != '0) && trace_ready;
    // The DM entry goes in after the GRF entry when both are pushed.
    dm_slot  = wr_ptr_q + ADDR_W'(push_grf);

    wr_ptr_d   = wr_ptr_q + ADDR_W'(n_push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    count_d    = count_q + (ADDR_W+1)'(n_push) - (ADDR_W+1)'(pop);
    overflow_d = overflow_q || (n_drop != 2'd0);
    drop_sum   = {1'b0, dropped_q} + 17'(n_drop);
    dropped_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  // Storage is not cleared by reset. The pointers and count define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_grf) begin
        mem_kind[wr_ptr_q] <= 1'b0;
        mem_pc[wr_ptr_q]   <= pc;
        mem_addr[wr_ptr_q] <= {27'b0, grf_addr};
        mem_data[wr_ptr_q] <= grf_wdata;
      end
      if (push_dm) begin
        mem_kind[dm_slot] <= 1'b1;
        mem_pc[dm_slot]   <= pc;
        mem_addr[dm_slot] <= dm_addr;
        mem_data[dm_slot] <= dm_wdata;
      end
    end
  end

  always_comb begin
    trace_valid = (count_q != '0);
    trace_kind  = trace_valid ? mem_kind[rd_ptr_q] : 1'b0;
    trace_pc    = trace_valid ? mem_pc[rd_ptr_q]   : 32'd0;
    trace_addr  = trace_valid ? mem_addr[rd_ptr_q] : 32'd0;
    trace_data  = trace_valid ? mem_data[rd_ptr_q] : 32'd0;
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Testbench for wb_trace_fifo.
// A queue-based reference model predicts the accepted and dropped events.
// A negedge monitor checks the DUT outputs against that model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        grf_we = 1'b0;
  logic [4:0]  grf_addr = '0;
  logic [31:0] grf_wdata = '0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] pc = '0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic        trace_kind;
  logic [31:0] trace_pc, trace_addr, trace_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] dropped_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .pc(pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_kind(trace_kind), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data), .count(count), .overflow(overflow),
    .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  int   exp_count = 0;
  int   exp_drop  = 0;
  logic exp_ovf   = 1'b0;
  bit   mon_en    = 1'b0;
  int   total     = 0;
  int   bad       = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of stimulus starting from just after a rising edge,
  // applies the model to it, and returns 1 time unit after the next edge.
  task automatic cycle(input logic rst, input logic gwe, input logic [4:0] ga,
                       input logic [31:0] gd, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dd, input logic [31:0] pcv, input logic rdy);
    int start, free, npush, ndrop;
    bit gev, pop;
    reset = rst; grf_we = gwe; grf_addr = ga; grf_wdata = gd;
    dm_we = dwe; dm_addr = da; dm_wdata = dd; pc = pcv; trace_ready = rdy;
    start = exp_count;
    free  = DEPTH - start;
    npush = 0; ndrop = 0;
    gev   = gwe && (ga != 0);
    if (!rst) begin
      if (gev) begin
        if (free >= 1) begin sb.push_back('{1'b0, pcv, {27'b0, ga}, gd}); npush++; end
        else ndrop++;
      end
      if (dwe) begin
        if (free - npush >= 1) begin sb.push_back('{1'b1, pcv, da, dd}); npush++; end
        else ndrop++;
      end
    end
    pop = (start != 0) && rdy;
    @(posedge clk); #1;
    if (rst) begin
      sb.delete();
      exp_count = 0; exp_drop = 0; exp_ovf = 1'b0;
    end else begin
      exp_count = start + npush - int'(pop);
      exp_drop  = (exp_drop + ndrop > 65535) ? 65535 : exp_drop + ndrop;
      if (ndrop != 0) exp_ovf = 1'b1;
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic grf_push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p, input logic rdy);
    cycle(1'b0, 1'b1, a, d, 1'b0, 32'd0, 32'd0, p, rdy);
  endtask

  // Monitor: the inputs are stable at the falling edge, so a handshake seen
  // here is the pop that the next rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t e;
      chk("count", 128'(count), 128'(exp_count));
      chk("valid", 128'(trace_valid), 128'(exp_count != 0));
      chk("overflow", 128'(overflow), 128'(exp_ovf));
      chk("dropped", 128'(dropped_cnt), 128'(exp_drop));
      if (trace_valid && trace_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 128'(1), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("head", {31'b0, trace_kind, trace_pc, trace_addr, trace_data},
                      {31'b0, e.kind, e.pc, e.addr, e.data});
        end
      end else if (!trace_valid) begin
        chk("idle_zero", {31'b0, trace_kind, trace_pc, trace_addr, trace_data}, 128'(0));
      end
    end
  end

  initial begin
    // 1: reset, then one GRF write shows up at the head after a single edge
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    mon_en = 1'b1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_valid", 128'(trace_valid), 128'(0));
    grf_push(5'd8, 32'h1234, 32'h3000, 1'b0);
    chk("t1_valid", 128'(trace_valid), 128'(1));
    chk("t1_head", {31'b0, trace_kind, trace_pc, trace_addr, trace_data},
                   {31'b0, 1'b0, 32'h3000, 32'd8, 32'h1234});
    chk("t1_count", 128'(count), 128'(1));
    idle(1'b1, 2);

    // 2: writes to $zero are filtered out and are not counted as drops
    for (int i = 0; i < 3; i++) grf_push(5'd0, 32'hdead, 32'h3000, 1'b0);
    chk("t2_count", 128'(count), 128'(0));
    chk("t2_drop", 128'(dropped_cnt), 128'(0));

    // 3: dual event, GRF ahead of DM
    cycle(1'b0, 1'b1, 5'd2, 32'd5, 1'b1, 32'h10, 32'd7, 32'h3004, 1'b1);
    chk("t3_head_kind", 128'(trace_kind), 128'(0));
    idle(1'b1, 3);
    chk("t3_count", 128'(count), 128'(0));

    // 4: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) grf_push(5'(i % 31 + 1), 32'(i + 100), 32'h4000 + 32'(4 * i), 1'b0);
    chk("t4_count", 128'(count), 128'(16));
    chk("t4_drop", 128'(dropped_cnt), 128'(1));
    chk("t4_ovf", 128'(overflow), 128'(1));
    idle(1'b1, 17);

    // 5: with one slot left, the GRF event is kept and the DM event is dropped
    for (int i = 0; i < 15; i++) grf_push(5'd3, 32'(i), 32'h5000, 1'b0);
    cycle(1'b0, 1'b1, 5'd4, 32'haa, 1'b1, 32'h20, 32'hbb, 32'h5100, 1'b1);
    chk("t5_count", 128'(count), 128'(15));
    chk("t5_drop", 128'(dropped_cnt), 128'(2));
    idle(1'b1, 16);

    // 6: reset with entries queued
    for (int i = 0; i < 9; i++) grf_push(5'd5, 32'(i), 32'h6000, 1'b0);
    chk("t6_pre", 128'(count), 128'(9));
    cycle(1'b1, 1'b1, 5'd6, 32'h77, 1'b1, 32'h30, 32'h88, 32'h6100, 1'b0);
    chk("t6_count", 128'(count), 128'(0));
    chk("t6_valid", 128'(trace_valid), 128'(0));
    chk("t6_ovf", 128'(overflow), 128'(0));
    grf_push(5'd9, 32'h99, 32'h6200, 1'b0);
    chk("t6_head", {31'b0, trace_kind, trace_pc, trace_addr, trace_data, 27'b0, count},
                   {31'b0, 1'b0, 32'h6200, 32'd9, 32'h99, 27'b0, 5'd1});
    idle(1'b1, 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ga;
      ga = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, ga, $urandom,
            $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0 ? (i % 400 < 200) : $urandom_range(0, 1) == 1);
    end
    idle(1'b1, 20);
    chk("final_count", 128'(count), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
